// File: rtl/alu_exec_stage.sv
// alu_exec_stage: RV32I integer execute stage with a registered EX/MEM
// result slot and a valid/ready handshake on both sides. Add/sub/compare/
// logic ops complete in one cycle; shifts run on an iterative 1-bit/cycle
// shifter and hold off upstream through in_ready until the result is ready.

module alu_exec_stage #(
  parameter int word_width   = 32,
  parameter int alu_op_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [word_width-1:0]   alu_a,
  input  logic [word_width-1:0]   alu_b,
  input  logic [alu_op_width-1:0] alu_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [word_width-1:0]   alu_result,
  output logic                    alu_zero
);

  localparam int shamt_width = $clog2(word_width);

  // funct3 encodings (upper three bits of alu_op)
  localparam logic [2:0] f3_add_sub = 3'b000;
  localparam logic [2:0] f3_sll     = 3'b001;
  localparam logic [2:0] f3_slt     = 3'b010;
  localparam logic [2:0] f3_sltu    = 3'b011;
  localparam logic [2:0] f3_xor     = 3'b100;
  localparam logic [2:0] f3_srl_sra = 3'b101;
  localparam logic [2:0] f3_or      = 3'b110;
  localparam logic [2:0] f3_and     = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  // Op decode
  logic [2:0]             funct3;
  logic                   alt;
  logic [shamt_width-1:0] shamt;
  logic                   is_shift;

  // Handshake / sequencing controls
  logic accept;
  logic load_direct;
  logic start_shift;
  logic shift_step;
  logic shift_done;

  // Single-cycle result path
  logic [word_width-1:0] direct_result;

  // Iterative shifter state
  logic [word_width-1:0]  acc;
  logic [shamt_width-1:0] cnt;
  logic                   dir_left;
  logic                   arith;

  // One-bit shift step; a right arithmetic step copies the current MSB,
  // which is always the operand's original sign bit.
  function automatic logic [word_width-1:0] shift_one(
    input logic [word_width-1:0] value,
    input logic                  left,
    input logic                  arith_right
  );
    if (left) begin
      return {value[word_width-2:0], 1'b0};
    end
    return {arith_right & value[word_width-1], value[word_width-1:1]};
  endfunction

  assign funct3   = alu_op[alu_op_width-1 -: 3];
  assign alt      = alu_op[0];
  assign shamt    = alu_b[shamt_width-1:0];
  assign is_shift = (funct3 == f3_sll) || (funct3 == f3_srl_sra);

  // Compute the single-cycle result; shift ops only take this path when
  // shamt is zero, where the result is simply alu_a.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    direct_result = '0;
    case (funct3)
      f3_add_sub: direct_result = alt ? (alu_a - alu_b) : (alu_a + alu_b);
      f3_sll:     direct_result = alu_a;
      f3_slt:     direct_result = {{(word_width-1){1'b0}},
                                   ($signed(alu_a) < $signed(alu_b))};
      f3_sltu:    direct_result = {{(word_width-1){1'b0}}, (alu_a < alu_b)};
      f3_xor:     direct_result = alu_a ^ alu_b;
      f3_srl_sra: direct_result = alu_a;
      f3_or:      direct_result = alu_a | alu_b;
      f3_and:     direct_result = alu_a & alu_b;
      default:    direct_result = '0;
    endcase
  end

  // FSM state register; reset and flush both abandon any shift in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst || flush) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: enter SHIFT on a nonzero-shift accept, leave when done.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_shift) next_state = SHIFT;
      SHIFT:   if (shift_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: handshake and datapath sequencing strobes.
  always_comb begin
    in_ready    = (state == IDLE) && !flush && (!out_valid || out_ready);
    accept      = in_valid && in_ready;
    load_direct = accept && (!is_shift || (shamt == '0));
    start_shift = accept && is_shift && (shamt != '0);
    shift_step  = (state == SHIFT) && (cnt != '0);
    shift_done  = (state == SHIFT) && (cnt == '0);
  end

  // Output slot and shift counter: written by a direct result or a finished
  // shift, otherwise drained when downstream takes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      alu_zero   <= 1'b1;
      cnt        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (load_direct) begin
        out_valid  <= 1'b1;
        alu_result <= direct_result;
        alu_zero   <= (direct_result == '0);
      end else if (shift_done) begin
        out_valid  <= 1'b1;
        alu_result <= acc;
        alu_zero   <= (acc == '0);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (start_shift) begin
        cnt <= shamt - 1'b1;
      end else if (shift_step) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Shifter accumulator: the accept edge already performs the first step,
  // each further SHIFT cycle performs one more.
  always_ff @(posedge clk) begin
    // NOTE: acc/dir_left/arith are pure datapath, only meaningful after a
    // shift start loads them, so they carry no reset.
    if (start_shift) begin
      acc      <= shift_one(alu_a, (funct3 == f3_sll),
                            (funct3 == f3_srl_sra) && alt);
      dir_left <= (funct3 == f3_sll);
      arith    <= (funct3 == f3_srl_sra) && alt;
    end else if (shift_step) begin
      acc <= shift_one(acc, dir_left, arith);
    end
  end

endmodule
